// File: rtl/hist_topk_pkg.sv
// Shared definitions for the histogram / top-K engine.
//   state_t  : engine FSM states
//   f_clog2  : ceiling log2 for elaboration-time widths
//   f_sum_w  : width of a bin sum across all histogram banks
package hist_topk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT,
    SCAN,
    FLUSH,
    DONE
  } state_t;

  function automatic int f_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  function automatic int f_sum_w(input int cnt_w, input int num_ch);
    return cnt_w + f_clog2(num_ch);
  endfunction

endpackage

// File: rtl/hist_topk_engine_slot.sv
// One ranked slot of the top-K insertion sorter.
// Holds {data, count, valid}. On an incoming {bin, sum}, it takes the upstream
// slot's value when the upstream slot is being displaced, otherwise it takes
// the incoming value when the sum strictly beats its own count. Equal sums
// never displace, so the earlier (lower) bin keeps the higher rank.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   i_clr                     synchronous clear of the slot
//   i_in_vld/data/count       candidate bin and its summed count
//   i_up_valid/data/count     value of the next-higher slot
//   o_valid/data/count        this slot's value, forwarded downstream
module topk_slot
  import hist_topk_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int SUM_W     = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_clr,
  input  logic                 i_in_vld,
  input  logic [DATA_SIZE-1:0] i_in_data,
  input  logic [SUM_W-1:0]     i_in_count,
  input  logic                 i_up_valid,
  input  logic [DATA_SIZE-1:0] i_up_data,
  input  logic [SUM_W-1:0]     i_up_count,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data,
  output logic [SUM_W-1:0]     o_count
);

  logic                 r_valid;
  logic [DATA_SIZE-1:0] r_data;
  logic [SUM_W-1:0]     r_count;
  logic                 w_take_up;
  logic                 w_take_in;

  // Upstream is displaced exactly when the candidate beats it; the sorted
  // order guarantees this slot is then beaten too, so the value shifts down.
  assign w_take_up = i_in_vld && (!i_up_valid || (i_in_count > i_up_count));
  assign w_take_in = i_in_vld && (!r_valid || (i_in_count > r_count));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (w_take_up) begin
      r_valid <= i_up_valid;
      r_data  <= i_up_data;
      r_count <= i_up_count;
    end else if (w_take_in) begin
      r_valid <= 1'b1;
      r_data  <= i_in_data;
      r_count <= i_in_count;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/hist_topk_engine.sv
// Histogram / top-K engine. A Collect window's samples are spread round-robin
// over NUM_CH flop histogram banks; the bins are then scanned, summed across
// banks and ranked by a chain of TOP_K insertion slots.
// Optional feature macro: HIST_LIMIT_EN (caps a window at LENGTH samples and
// drives a sticky Overflow; otherwise bank counters saturate and Overflow=0).
// Ports:
//   clk, rstn   clock, async active-low reset
//   Collect     window gate (rising edge in IDLE starts a run)
//   Valid/Data  sample strobe and value, counted only while Ready
//   Ready       high in COLLECT
//   Busy        high outside IDLE
//   Overflow    sticky sample-dropped flag
//   SortValid   one-cycle pulse when MaxData/MaxCount are final
//   MaxData     TOP_K bin indices, slot 0 (largest) in the low bits
//   MaxCount    TOP_K summed counts, same slot layout
module hist_topk_engine
  import hist_topk_pkg::*;
#(
  parameter  int DATA_SIZE   = 4,
  parameter  int NUM_CH      = 4,
  parameter  int LENGTH      = 64,
  parameter  int LENGTH_SIZE = 6,
  parameter  int TOP_K       = 3,
  localparam int CNT_W       = LENGTH_SIZE + 1,
  localparam int SUM_W       = f_sum_w(CNT_W, NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       Collect,
  input  logic                       Valid,
  input  logic [DATA_SIZE-1:0]       Data,
  output logic                       Ready,
  output logic                       Busy,
  output logic                       Overflow,
  output logic                       SortValid,
  output logic [TOP_K*DATA_SIZE-1:0] MaxData,
  output logic [TOP_K*SUM_W-1:0]     MaxCount
);

  localparam int DATA_NUM = 2 ** DATA_SIZE;
  localparam int CH_W     = (NUM_CH > 1) ? f_clog2(NUM_CH) : 1;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_collect_d;
  logic                       w_rise;
  logic [DATA_SIZE-1:0]       r_bin;
  logic [CH_W-1:0]            r_ch;
  logic [CNT_W-1:0]           r_bank [NUM_CH][DATA_NUM];
  logic [SUM_W-1:0]           w_sum;
  logic [SUM_W-1:0]           r_sum;
  logic [DATA_SIZE-1:0]       r_sum_bin;
  logic                       r_sum_vld;
  logic                       r_sort_valid;
  logic [TOP_K*DATA_SIZE-1:0] r_max_data;
  logic [TOP_K*SUM_W-1:0]     r_max_count;
  logic                       w_accept;
  logic                       w_slot_valid [TOP_K];
  logic [DATA_SIZE-1:0]       w_slot_data  [TOP_K];
  logic [SUM_W-1:0]           w_slot_count [TOP_K];

  assign w_rise = Collect && !r_collect_d;
  assign Ready  = (r_state == COLLECT);
  assign Busy   = (r_state != IDLE);

`ifdef HIST_LIMIT_EN
  logic [CNT_W-1:0] r_taken;
  logic             r_overflow;
  logic             w_at_cap;

  assign w_at_cap = (r_taken >= CNT_W'(LENGTH));
  assign w_accept = Ready && Valid && !w_at_cap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_taken    <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_taken    <= '0;
      r_overflow <= 1'b0;
    end else if (Ready && Valid) begin
      if (w_at_cap) r_overflow <= 1'b1;
      else          r_taken    <= r_taken + CNT_W'(1);
    end
  end

  assign Overflow = r_overflow;
`else
  assign w_accept = Ready && Valid;
  assign Overflow = 1'b0;
`endif

  // NOTE: state and counters use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_next = CLEAR;
      CLEAR:   if (r_bin == DATA_SIZE'(DATA_NUM - 1)) w_next = Collect ? COLLECT : SCAN;
      COLLECT: if (!Collect) w_next = SCAN;
      SCAN:    if (r_bin == DATA_SIZE'(DATA_NUM - 1)) w_next = FLUSH;
      FLUSH:   if (r_bin == DATA_SIZE'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the banks are a reset flop array, not a RAM, so every bin is
  // cleared by rstn and back-to-back increments of one bin need no bypass.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int b = 0; b < DATA_NUM; b++)
          r_bank[c][b] <= '0;
    end else if (r_state == CLEAR) begin
      for (int c = 0; c < NUM_CH; c++) r_bank[c][r_bin] <= '0;
    end else if (w_accept && (r_bank[r_ch][Data] != {CNT_W{1'b1}})) begin
      r_bank[r_ch][Data] <= r_bank[r_ch][Data] + CNT_W'(1);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CH; c++) w_sum = w_sum + SUM_W'(r_bank[c][r_bin]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_collect_d  <= 1'b0;
      r_bin        <= '0;
      r_ch         <= '0;
      r_sum        <= '0;
      r_sum_bin    <= '0;
      r_sum_vld    <= 1'b0;
      r_sort_valid <= 1'b0;
      r_max_data   <= '0;
      r_max_count  <= '0;
    end else begin
      r_collect_d  <= Collect;
      r_sum_vld    <= (r_state == SCAN);
      r_sort_valid <= (r_state == DONE);
      // Single bin/phase counter; it wraps to 0 at the end of CLEAR and SCAN,
      // which also makes it the FLUSH cycle counter.
      case (r_state)
        CLEAR, SCAN, FLUSH: r_bin <= r_bin + DATA_SIZE'(1);
        default:            r_bin <= '0;
      endcase
      if (r_state == CLEAR) r_ch <= '0;
      else if (w_accept)    r_ch <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
      if (r_state == SCAN) begin
        r_sum     <= w_sum;
        r_sum_bin <= r_bin;
      end
      if (r_state == CLEAR) begin
        r_max_data  <= '0;
        r_max_count <= '0;
      end else if (r_state == DONE) begin
        for (int k = 0; k < TOP_K; k++) begin
          r_max_data[k*DATA_SIZE +: DATA_SIZE] <= w_slot_valid[k] ? w_slot_data[k] : '0;
          r_max_count[k*SUM_W +: SUM_W]        <= w_slot_valid[k] ? w_slot_count[k] : '0;
        end
      end
    end
  end

  for (genvar k = 0; k < TOP_K; k++) begin : g_slot
    logic                 w_up_valid;
    logic [DATA_SIZE-1:0] w_up_data;
    logic [SUM_W-1:0]     w_up_count;
    if (k == 0) begin : g_head
      // A full, maximal virtual slot above the head: it can never be beaten.
      assign w_up_valid = 1'b1;
      assign w_up_data  = '0;
      assign w_up_count = {SUM_W{1'b1}};
    end else begin : g_link
      assign w_up_valid = w_slot_valid[k-1];
      assign w_up_data  = w_slot_data[k-1];
      assign w_up_count = w_slot_count[k-1];
    end
    topk_slot #(
      .DATA_SIZE(DATA_SIZE),
      .SUM_W    (SUM_W)
    ) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .i_clr     (r_state == CLEAR),
      .i_in_vld  (r_sum_vld && (r_sum != '0)),
      .i_in_data (r_sum_bin),
      .i_in_count(r_sum),
      .i_up_valid(w_up_valid),
      .i_up_data (w_up_data),
      .i_up_count(w_up_count),
      .o_valid   (w_slot_valid[k]),
      .o_data    (w_slot_data[k]),
      .o_count   (w_slot_count[k])
    );
  end

  assign SortValid = r_sort_valid;
  assign MaxData   = r_max_data;
  assign MaxCount  = r_max_count;

endmodule
